branch_pc_unit: RTL

- Program-counter and branch-resolution stage directly downstream of the ALU.
- Consumes the ALU's zero/negative flags combinationally and its carry output through a latched carry flag.
- Resolves the eight branch opcodes, updates the PC, and issues a one-cycle flush bubble after every taken branch.
- Drives fetch address and link-register write-back.

---
 rtl/branch_pc_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - PC update and branch resolution with one-cycle flush after taken branches
// Optional macro BRANCH_STATS_EN adds saturating branch/taken counters.
module branch_pc_unit #(
   parameter int               PC_W     = 32,
   parameter logic [PC_W-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic [1:0]      alu_sign,
   input  logic            alu_cout,
   input  logic            flag_we,
   input  logic            br_valid,
   input  logic [2:0]      br_op,
   input  logic [PC_W-1:0] br_target,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus4,
   output logic            taken,
   output logic            link_we,
   output logic [PC_W-1:0] link_addr,
   output logic            flush
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]     br_cnt,
   output logic [15:0]     taken_cnt
`endif
);

   typedef enum logic {RUN, REDIRECT} state_t;

   state_t state;
   logic   cy_q;
   logic   cond;

   always_comb begin
      cond = 1'b0;
      case (br_op)
         3'b000:  cond = 1'b1;
         3'b001:  cond = 1'b1;
         3'b010:  cond = alu_sign[1];
         3'b011:  cond = ~alu_sign[1];
         3'b100:  cond = alu_sign[0];
         3'b101:  cond = 1'b1;
         3'b110:  cond = cy_q;
         3'b111:  cond = ~cy_q;
         default: cond = 1'b0;
      endcase
   end

   assign pc_plus4  = pc + PC_W'(4);
   assign link_addr = pc_plus4;
   assign taken     = br_valid & (state == RUN) & cond;
   assign link_we   = br_valid & (br_op == 3'b101) & (state == RUN) & ~stall;

   // flush mirrors the REDIRECT state but is kept as its own register output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= RESET_PC;
         state <= RUN;
         cy_q  <= 1'b0;
         flush <= 1'b0;
      end else if (!stall) begin
         case (state)
            RUN: begin
               if (flag_we)
                  cy_q <= alu_cout;
               if (taken) begin
                  pc    <= {br_target[PC_W-1:2], 2'b00};
                  state <= REDIRECT;
                  flush <= 1'b1;
               end else begin
                  pc <= pc_plus4;
               end
            end
            REDIRECT: begin
               pc    <= pc_plus4;
               state <= RUN;
               flush <= 1'b0;
            end
            default: begin
               state <= RUN;
               flush <= 1'b0;
            end
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cnt    <= 16'h0000;
         taken_cnt <= 16'h0000;
      end else if (!stall && state == RUN) begin
         if (br_valid && br_cnt != 16'hFFFF)
            br_cnt <= br_cnt + 16'h0001;
         if (taken && taken_cnt != 16'hFFFF)
            taken_cnt <= taken_cnt + 16'h0001;
      end
   end
`endif

endmodule
